// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 9;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Requester identity
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    // The port that is not the given one
    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb_pick.sv
// Two-way winner selection. On a tie the port that did not win last time is
// chosen; feeding a constant PORT1 as last winner gives fixed port-0 priority.
module arb_pick
    import dmem_arb_pkg::*;
(
    input  logic     req0_i,
    input  logic     req1_i,
    input  port_id_e last_i,
    output port_id_e winner_o,
    output logic     valid_o
);

    // Combinational pick: single requester wins outright, tie goes away from last
    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = PORT0;
        if (req0_i && req1_i) begin
            winner_o = other_port(last_i);
        end else if (req1_i) begin
            winner_o = PORT1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core datapath (port 0) and loader/debug
// (port 1) share a single-ported synchronous memory.
// Sequence per access: IDLE (capture) -> ACCESS (strobe, gnt) -> RESP (reads
// only, rvalid). Define DMEM_ARB_RR_EN for round-robin tie resolution;
// otherwise port 0 always wins ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    state_e            state_q, state_d;
    port_id_e          win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    port_id_e          last_win;
    port_id_e          pick_winner;
    logic              pick_valid;

`ifdef DMEM_ARB_RR_EN
    port_id_e          last_q, last_d;

    assign last_win = last_q;

    // Round-robin pointer; starts at port 1 so port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign last_win = PORT1;
`endif

    arb_pick u_pick (
        .req0_i   (p0_req),
        .req1_i   (p1_req),
        .last_i   (last_win),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    // State, request latch and per-port read-data holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            win_q    <= PORT0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state, capture and output decode
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef DMEM_ARB_RR_EN
        last_d   = last_q;
`endif

        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        p0_rdata  = rdata0_q;
        p1_rdata  = rdata1_q;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d = pick_winner;
                    if (pick_winner == PORT0) begin
                        we_d    = p0_we;
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                    end else begin
                        we_d    = p1_we;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                    end
`ifdef DMEM_ARB_RR_EN
                    last_d = pick_winner;
`endif
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                mem_wr = we_q;
                mem_rd = ~we_q;
                p0_gnt = (win_q == PORT0);
                p1_gnt = (win_q == PORT1);
                state_d = we_q ? IDLE : RESP;
            end

            RESP: begin
                // Memory data arrives this cycle: forward it alongside rvalid
                // and keep a registered copy for the hold period afterwards.
                if (win_q == PORT0) begin
                    p0_rvalid = 1'b1;
                    p0_rdata  = mem_rdata;
                    rdata0_d  = mem_rdata;
                end else begin
                    p1_rvalid = 1'b1;
                    p1_rdata  = mem_rdata;
                    rdata1_d  = mem_rdata;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Invariants of the access sequence
    a_strobe_excl: assert property (@(posedge clk) !(mem_wr && mem_rd));
    a_gnt_excl:    assert property (@(posedge clk) !(p0_gnt && p1_gnt));
    a_rvalid_excl: assert property (@(posedge clk) !(p0_rvalid && p1_rvalid));

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter ADDR_W, default 9, data-memory word address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 p0_req  input  1  port 0 (core datapath) access request.
REQ-006 p0_we  input  1  port 0 write (1) / read (0).
REQ-007 p0_addr  input  ADDR_W  port 0 address.
REQ-008 p0_wdata  input  DATA_W  port 0 write data.
REQ-009 p0_gnt  output  1  port 0 request accepted, one-cycle pulse.
REQ-010 p0_rvalid  output  1  port 0 read data valid, one-cycle pulse.
REQ-011 p0_rdata  output  DATA_W  port 0 read data.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same directions, widths and meanings for port 1 (loader/debug).
REQ-013 mem_wr  output  1  memory write strobe.
REQ-014 mem_rd  output  1  memory read strobe.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_rd.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-020 IDLE: if any req is high, pick a winner, latch its we/addr/wdata and port id, go to ACCESS; otherwise stay.
REQ-021 ACCESS: drive mem_wr=we, mem_rd=~we, mem_addr/mem_wdata from the latch, pulse winner's gnt; go to RESP if read, IDLE if write.
REQ-022 RESP: register mem_rdata into winner's rdata, pulse winner's rvalid; go to IDLE.
REQ-023 Latency: req seen in IDLE at cycle N -> gnt and mem strobe at N+1 -> rvalid at N+2 (reads); throughput one write per 2 cycles, one read per 3 cycles.
REQ-024 mem_wr and mem_rd SHALL never be high together and SHALL be low outside ACCESS.
REQ-025 gnt and rvalid SHALL never be high for both ports in the same cycle.
REQ-026 Requests arriving while not in IDLE SHALL wait; requesters hold req/we/addr/wdata until gnt.
REQ-027 Deasserting req after capture (before gnt) SHALL NOT cancel the access; it completes with latched values.
REQ-028 pX_rdata SHALL hold its last value until the next rvalid on that port.

Reset
REQ-029 On reset: state IDLE; all gnt, rvalid, mem_wr, mem_rd, busy = 0; mem_addr, mem_wdata, p0_rdata, p1_rdata = 0; round-robin pointer = port 1 (so port 0 wins first tie).
REQ-030 Reset asserted in ACCESS or RESP SHALL abort: no gnt/rvalid pulse in the following cycle.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN: when defined, ties SHALL be resolved round-robin (winner is the port not granted last; pointer updates on each capture).
REQ-032 Without DMEM_ARB_RR_EN, port 0 SHALL always win ties; no pointer register exists.
REQ-033 Single-requester behaviour SHALL be identical in both configurations.

Structure
REQ-034 Package dmem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), port-id type and DEFAULT_DATA_W=32 / DEFAULT_ADDR_W=9 constants.
REQ-035 Winner selection SHALL be a sub-module arb_pick (inputs: two reqs, last-winner; output: winner id, valid).

Verification
REQ-036 Reset then p0 write addr 0x010 data 0xDEADBEEF -> cycle+1: p0_gnt=1, mem_wr=1, mem_addr=0x010, mem_wdata=0xDEADBEEF; busy low after.
REQ-037 p1 read addr 0x010 with memory returning 0xDEADBEEF -> gnt at N+1, p1_rvalid=1 and p1_rdata=0xDEADBEEF at N+2, p0 outputs quiet.
REQ-038 Both ports request reads continuously, fixed priority build -> only p0 granted; DMEM_ARB_RR_EN build -> grants alternate p0,p1,p0,p1.
REQ-039 p1 requests during p0 read in ACCESS -> p1 captured only after return to IDLE; no overlapping strobes.
REQ-040 reset asserted during RESP -> next cycle rvalid=0, state IDLE, all outputs at reset values.
